pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/ctrl_down_counter.sv | 30 +++
 rtl/pipe_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned B_IFID  = 0;
  localparam int unsigned B_IDEX  = 1;
  localparam int unsigned B_EXMEM = 2;
  localparam int unsigned B_MEMWB = 3;

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_MEM_WAIT  = 2'd1,
    S_INT_DRAIN = 2'd2,
    S_INT_VECT  = 2'd3
  } state_t;

endpackage

// File: rtl/ctrl_down_counter.sv
// Loadable down counter that saturates at zero and flags the zero count.
module ctrl_down_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero_c
);

  logic [W-1:0] count;

  // Load wins over decrement; never wraps below zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use, branch, multi-word memory and interrupt sequencing.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_CYCLES = 2,
  parameter int unsigned INT_DRAIN  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_use,
  input  logic       branch_taken,
  input  logic       mem_multi,
  input  logic       int_req,
  output logic [3:0] stall,
  output logic [3:0] flush,
  output logic       pc_stall,
  output logic       pc_sel_int,
  output logic       int_ack
);

  state_t state, state_next;
  state_t ret, ret_next;
  logic   int_pending;
  logic   cnt_load, cnt_en, cnt_zero;
  logic   dcnt_load, dcnt_en, dcnt_zero;

  ctrl_down_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CNT_W'(MEM_CYCLES - 1)),
    .en       (cnt_en),
    .zero_c   (cnt_zero)
  );

  ctrl_down_counter #(.W(CNT_W)) u_dcnt (
    .clk      (clk),
    .reset    (reset),
    .load     (dcnt_load),
    .load_val (CNT_W'(INT_DRAIN - 1)),
    .en       (dcnt_en),
    .zero_c   (dcnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_RUN;
      ret         <= S_RUN;
      int_pending <= 1'b0;
    end else begin
      state       <= state_next;
      ret         <= ret_next;
      // A request in the vector cycle survives the clear.
      int_pending <= int_req | (int_pending & (state != S_INT_VECT));
    end
  end

  always_comb begin
    state_next = state;
    ret_next   = ret;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    dcnt_load  = 1'b0;
    dcnt_en    = 1'b0;
    stall      = '0;
    flush      = '0;
    pc_stall   = 1'b0;
    pc_sel_int = 1'b0;
    int_ack    = 1'b0;

    unique case (state)
      S_RUN: begin
        if (mem_multi) begin
          stall[B_EXMEM:B_IFID] = 3'b111;
          flush[B_MEMWB]        = 1'b1;
          pc_stall              = 1'b1;
          cnt_load              = 1'b1;
          ret_next              = S_RUN;
          state_next            = S_MEM_WAIT;
        end else begin
          if (branch_taken) begin
            flush[B_IDEX:B_IFID] = 2'b11;
          end else if (load_use) begin
            pc_stall       = 1'b1;
            stall[B_IFID]  = 1'b1;
            flush[B_IDEX]  = 1'b1;
          end
          if (int_pending) begin
            dcnt_load  = 1'b1;
            state_next = S_INT_DRAIN;
          end
        end
      end

      S_MEM_WAIT: begin
        stall[B_EXMEM:B_IFID] = 3'b111;
        flush[B_MEMWB]        = 1'b1;
        pc_stall              = 1'b1;
        if (cnt_zero) begin
          state_next = ret;
        end else begin
          cnt_en = 1'b1;
        end
      end

      S_INT_DRAIN: begin
        if (mem_multi) begin
          // Drain count stays frozen while the memory op holds the pipe.
          stall[B_EXMEM:B_IFID] = 3'b111;
          flush[B_MEMWB]        = 1'b1;
          pc_stall              = 1'b1;
          cnt_load              = 1'b1;
          ret_next              = S_INT_DRAIN;
          state_next            = S_MEM_WAIT;
        end else begin
          pc_stall      = 1'b1;
          flush[B_IFID] = 1'b1;
          flush[B_IDEX] = branch_taken;
          if (dcnt_zero) begin
            state_next = S_INT_VECT;
          end else begin
            dcnt_en = 1'b1;
          end
        end
      end

      S_INT_VECT: begin
        pc_sel_int    = 1'b1;
        int_ack       = 1'b1;
        flush[B_IFID] = 1'b1;
        state_next    = S_RUN;
      end

      default: state_next = S_RUN;
    endcase

    // Outputs are forced quiet the moment reset rises.
    if (reset) begin
      stall      = '0;
      flush      = '0;
      pc_stall   = 1'b0;
      pc_sel_int = 1'b0;
      int_ack    = 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed sequences plus randomized traffic against a cycle-count model.
module tb_pipe_ctrl;

  localparam int MEM_CYCLES = 2;
  localparam int INT_DRAIN  = 3;

  // Packed as {stall[3:0], flush[3:0], pc_stall, pc_sel_int, int_ack}
  localparam logic [10:0] IDLE_O     = 11'b0000_0000_000;
  localparam logic [10:0] LU_O       = 11'b0001_0010_100;
  localparam logic [10:0] BR_O       = 11'b0000_0011_000;
  localparam logic [10:0] MEM_O      = 11'b0111_1000_100;
  localparam logic [10:0] DRAIN_O    = 11'b0000_0001_100;
  localparam logic [10:0] DRAIN_BT_O = 11'b0000_0011_100;
  localparam logic [10:0] VECT_O     = 11'b0000_0001_011;

  localparam logic [3:0] V_IDLE = 4'b0000;  // {load_use, branch_taken, mem_multi, int_req}
  localparam logic [3:0] V_LU   = 4'b1000;
  localparam logic [3:0] V_BT   = 4'b0100;
  localparam logic [3:0] V_MM   = 4'b0010;
  localparam logic [3:0] V_IR   = 4'b0001;
  localparam logic [3:0] V_BTLU = 4'b1100;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_use, branch_taken, mem_multi, int_req;
  logic [3:0] stall, flush;
  logic       pc_stall, pc_sel_int, int_ack;
  logic [10:0] act;

  int vectors = 0;
  int miscompares = 0;

  // Model: remaining MEM_WAIT cycles, remaining drain cycles, vector-cycle flag, pending flag
  int m_mem = 0;
  int m_drain = 0;
  bit m_vect = 1'b0;
  bit m_pend = 1'b0;

  bit ack_watch = 1'b0;
  bit ack_seen = 1'b0;

  pipe_ctrl #(.MEM_CYCLES(MEM_CYCLES), .INT_DRAIN(INT_DRAIN)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_use     (load_use),
    .branch_taken (branch_taken),
    .mem_multi    (mem_multi),
    .int_req      (int_req),
    .stall        (stall),
    .flush        (flush),
    .pc_stall     (pc_stall),
    .pc_sel_int   (pc_sel_int),
    .int_ack      (int_ack)
  );

  always #5 clk = ~clk;

  assign act = {stall, flush, pc_stall, pc_sel_int, int_ack};

  function automatic logic [10:0] model_out();
    if (reset) return IDLE_O;
    if (m_mem > 0 || (mem_multi && !m_vect)) return MEM_O;
    if (m_vect) return VECT_O;
    if (m_drain > 0) return branch_taken ? DRAIN_BT_O : DRAIN_O;
    if (branch_taken) return BR_O;
    if (load_use) return LU_O;
    return IDLE_O;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend  <= 1'b0;
      m_mem   <= 0;
      m_drain <= 0;
      m_vect  <= 1'b0;
    end else begin
      m_pend <= int_req | (m_pend & ~m_vect);
      if (m_mem > 0) begin
        m_mem <= m_mem - 1;
      end else if (m_vect) begin
        m_vect <= 1'b0;
      end else if (mem_multi) begin
        m_mem <= MEM_CYCLES;
      end else if (m_drain > 0) begin
        m_drain <= m_drain - 1;
        if (m_drain == 1) m_vect <= 1'b1;
      end else if (m_pend) begin
        m_drain <= INT_DRAIN;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    logic [10:0] exp;
    exp = model_out();
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL model t=%0t got stall=%b flush=%b pcs=%b psi=%b ack=%b want %b", $time,
               stall, flush, pc_stall, pc_sel_int, int_ack, exp);
    end
    if (ack_watch && int_ack) ack_seen <= 1'b1;
  end

  task automatic check(input string nm, input logic [10:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  // Called at posedge+1: apply inputs for one cycle, optionally pin the outputs to a literal.
  task automatic cyc(input logic [3:0] v, input string nm, input logic [10:0] exp, input bit chk);
    {load_use, branch_taken, mem_multi, int_req} = v;
    @(negedge clk);
    #1;
    if (chk) check(nm, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    {load_use, branch_taken, mem_multi, int_req} = 4'b1100;
    #3;
    check("reset_outputs", IDLE_O);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    {load_use, branch_taken, mem_multi, int_req} = V_IDLE;
    @(posedge clk); #1;

    cyc(V_IDLE, "first_run", IDLE_O, 1'b1);

    // Single load-use bubble
    cyc(V_LU,   "lu_cycle", LU_O,   1'b1);
    cyc(V_IDLE, "lu_after", IDLE_O, 1'b1);

    // Two-word memory op: trigger cycle plus MEM_CYCLES wait cycles
    cyc(V_MM,   "mem_trig",  MEM_O,  1'b1);
    cyc(V_IDLE, "mem_wait1", MEM_O,  1'b1);
    cyc(V_IDLE, "mem_wait2", MEM_O,  1'b1);
    cyc(V_IDLE, "mem_done",  IDLE_O, 1'b1);

    // Interrupt: latch, one RUN cycle, drain, vector
    cyc(V_IR,   "int_req",   IDLE_O,  1'b1);
    cyc(V_IDLE, "int_pend",  IDLE_O,  1'b1);
    cyc(V_IDLE, "drain1",    DRAIN_O, 1'b1);
    cyc(V_IDLE, "drain2",    DRAIN_O, 1'b1);
    cyc(V_BT,   "drain3_bt", DRAIN_BT_O, 1'b1);
    cyc(V_IDLE, "vect",      VECT_O,  1'b1);
    cyc(V_IDLE, "int_done",  IDLE_O,  1'b1);

    // Memory op interrupting the drain; frozen drain count resumes
    cyc(V_IR,   "i2_req",    IDLE_O,  1'b1);
    cyc(V_IDLE, "i2_pend",   IDLE_O,  1'b1);
    cyc(V_IDLE, "i2_drain1", DRAIN_O, 1'b1);
    cyc(V_MM,   "i2_mem",    MEM_O,   1'b1);
    cyc(V_IDLE, "i2_wait1",  MEM_O,   1'b1);
    cyc(V_IDLE, "i2_wait2",  MEM_O,   1'b1);
    cyc(V_IDLE, "i2_drain2", DRAIN_O, 1'b1);
    cyc(V_IDLE, "i2_drain3", DRAIN_O, 1'b1);
    // Request during the vector cycle must start another sequence
    cyc(V_IR,   "i2_vect",   VECT_O,  1'b1);
    cyc(V_IDLE, "i3_pend",   IDLE_O,  1'b1);
    cyc(V_IDLE, "i3_drain1", DRAIN_O, 1'b1);
    cyc(V_IDLE, "i3_drain2", DRAIN_O, 1'b1);
    cyc(V_IDLE, "i3_drain3", DRAIN_O, 1'b1);
    cyc(V_IDLE, "i3_vect",   VECT_O,  1'b1);

    // Branch wins over load-use
    cyc(V_BTLU, "bt_lu", BR_O, 1'b1);

    // Reset in the middle of a drain: quiet immediately, no acknowledge, pending lost
    cyc(V_IR,   "r_req",    IDLE_O,  1'b1);
    cyc(V_IDLE, "r_pend",   IDLE_O,  1'b1);
    cyc(V_IDLE, "r_drain1", DRAIN_O, 1'b1);
    ack_watch = 1'b1;
    load_use = 1'b1;
    reset = 1'b1;
    #1;
    check("reset_async", IDLE_O);
    @(posedge clk); #1;
    reset = 1'b0;
    load_use = 1'b0;
    for (int i = 0; i < 6; i++) cyc(V_IDLE, "post_reset", IDLE_O, 1'b1);
    ack_watch = 1'b0;
    vectors++;
    if (ack_seen) begin
      miscompares++;
      $display("FAIL no_ack_after_reset got int_ack=1 want 0");
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      load_use     = ($urandom_range(99) < 25);
      branch_taken = ($urandom_range(99) < 20);
      mem_multi    = ($urandom_range(99) < 6);
      int_req      = ($urandom_range(99) < 4);
      @(posedge clk); #1;
    end
    {load_use, branch_taken, mem_multi, int_req} = V_IDLE;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
    end
    check("settled_idle", IDLE_O);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
